// File: rtl/ah_demux_route_ctrl.sv
// Packet-aware route controller for the 24-way egress demux: decodes the header destination,
// holds demux_select for the whole packet, drops out-of-range destinations and counts packets.
module ah_demux_route_ctrl #(
    parameter int DATA_W   = 109,
    parameter int NUM_EGR  = 24,
    parameter int SEL_W    = 5,
    parameter int DEST_LSB = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_en,
    input  logic              cnt_clr,
    input  logic [DATA_W-1:0] ing_data,
    input  logic              ing_valid,
    input  logic              ing_last,
    output logic              ing_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  demux_select,
    output logic              route_active,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    // state | meaning
    // IDLE  | waiting for a header; decodes dest, nothing consumed
    // ROUTE | forwarding beats to the selected egress until the last beat
    // DROP  | swallowing every beat of an out-of-range packet
    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    localparam logic [SEL_W:0] EGR_LIM = (SEL_W+1)'(NUM_EGR);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] dest;
    logic             dest_ok;
    logic             hdr_take;
    logic             pkt_done;
    logic             drop_done;

    assign dest      = ing_data[DEST_LSB +: SEL_W];
    assign dest_ok   = ({1'b0, dest} < EGR_LIM);
    assign hdr_take  = (state == IDLE) && ing_valid && ctrl_en;
    assign pkt_done  = (state == ROUTE) && ing_valid && out_ready && ing_last;
    assign drop_done = (state == DROP) && ing_valid && ing_last;
    assign out_data  = ing_data;

    always_comb begin
        state_nxt    = state;
        out_valid    = 1'b0;
        ing_ready    = 1'b0;
        route_active = 1'b0;
        case (state)
            IDLE: begin
                if (hdr_take)
                    state_nxt = dest_ok ? ROUTE : DROP;
            end
            ROUTE: begin
                route_active = 1'b1;
                out_valid    = ing_valid;
                ing_ready    = out_ready;
                if (pkt_done)
                    state_nxt = IDLE;
            end
            DROP: begin
                ing_ready = 1'b1;
                if (drop_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            demux_select <= '0;
        end else begin
            state <= state_nxt;
            if (hdr_take)
                demux_select <= dest;
        end
    end

    // Clear wins over a same-cycle increment; drop count saturates, packet count wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (cnt_clr) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pkt_done)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (drop_done && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ah_demux_route_ctrl.sv
// Self-checking bench for ah_demux_route_ctrl: a scoreboard of expected routed beats
// (data + select) is filled as beats are driven and drained by a handshake monitor.
module tb_ah_demux_route_ctrl;

    localparam int DW = 109;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctrl_en;
    logic          cnt_clr;
    logic [DW-1:0] ing_data;
    logic          ing_valid;
    logic          ing_last;
    logic          ing_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    demux_select;
    logic          route_active;
    logic [15:0]   pkt_cnt;
    logic [15:0]   drop_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    sel;
    } beat_t;

    beat_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          in_drop = 0;
    logic [15:0] exp_pkt = 0;
    logic [15:0] exp_drop = 0;

    ah_demux_route_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .cnt_clr(cnt_clr),
        .ing_data(ing_data), .ing_valid(ing_valid), .ing_last(ing_last), .ing_ready(ing_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .demux_select(demux_select), .route_active(route_active),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Handshake monitor: every forwarded beat must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            beat_t e;
            total++;
            if (in_drop) begin
                bad++;
                $display("FAIL drop_leak: out_valid=1 during dropped packet, required 0");
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: beat %h forwarded with none expected", out_data);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || demux_select !== e.sel) begin
                    bad++;
                    $display("FAIL sb_beat: got data=%h sel=%0d, required data=%h sel=%0d",
                             out_data, demux_select, e.data, e.sel);
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk(input logic [4:0] dest);
        logic [127:0]  r;
        logic [DW-1:0] d;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        d = r[DW-1:0];
        d[4:0] = dest;
        return d;
    endfunction

    task automatic drive_beat(input logic [DW-1:0] d, input logic last, input bit push,
                              input logic [4:0] exp_sel, input logic clr, output int waits);
        bit acc;
        beat_t e;
        ing_data  = d;
        ing_valid = 1'b1;
        ing_last  = last;
        if (push) begin
            e.data = d;
            e.sel  = exp_sel;
            sb.push_back(e);
        end
        waits = 0;
        acc   = 0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            waits++;
            if (ing_ready === 1'b1) acc = 1;
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL beat_accept: ing_ready stayed low for %0d cycles, required 1", waits);
        end
        if (clr) cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr   = 1'b0;
        ing_valid = 1'b0;
        ing_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [4:0] dest, input int n, input bit route,
                            output int hdr_waits);
        int w;
        in_drop = !route;
        for (int i = 0; i < n; i++) begin
            drive_beat((i == 0) ? mk(dest) : mk(5'($urandom())), (i == n - 1), route, dest, 1'b0, w);
            if (i == 0) hdr_waits = w;
        end
        in_drop = 0;
        if (route) exp_pkt = exp_pkt + 16'd1;
        else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    endtask

    task automatic chk_cnt(input string name);
        total++;
        if (pkt_cnt !== exp_pkt || drop_cnt !== exp_drop) begin
            bad++;
            $display("FAIL %s: pkt_cnt=%h drop_cnt=%h, required pkt_cnt=%h drop_cnt=%h",
                     name, pkt_cnt, drop_cnt, exp_pkt, exp_drop);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ctrl_en = 1'b1; cnt_clr = 1'b0; ing_data = '0;
        ing_valid = 1'b0; ing_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (demux_select !== 5'd0 || route_active !== 1'b0 || out_valid !== 1'b0 ||
            ing_ready !== 1'b0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_vals: sel=%0d act=%b ov=%b ir=%b pkt=%h drop=%h, required all 0",
                     demux_select, route_active, out_valid, ing_ready, pkt_cnt, drop_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_route;
        int w;
        drive_beat(mk(5'd5), 1'b0, 1, 5'd5, 1'b0, w);
        total++;
        if (w !== 2 || demux_select !== 5'd5) begin
            bad++;
            $display("FAIL hdr_latency: waits=%0d sel=%0d, required waits=2 sel=5", w, demux_select);
        end
        drive_beat(mk(5'd17), 1'b0, 1, 5'd5, 1'b0, w);
        drive_beat(mk(5'd30), 1'b1, 1, 5'd5, 1'b0, w);
        exp_pkt = exp_pkt + 16'd1;
        total++;
        if (route_active !== 1'b0) begin
            bad++;
            $display("FAIL route_end: route_active=%b, required 0", route_active);
        end
        chk_cnt("single_cnt");
    endtask

    task automatic test_back_to_back;
        int w;
        int c0;
        logic [4:0] dl[3];
        dl[0] = 5'd0; dl[1] = 5'd23; dl[2] = 5'd7;
        c0 = cyc;
        for (int i = 0; i < 3; i++) send_pkt(dl[i], 1, 1, w);
        total++;
        if (cyc - c0 !== 6) begin
            bad++;
            $display("FAIL b2b_cycles: took %0d cycles, required 6", cyc - c0);
        end
        chk_cnt("b2b_cnt");
    endtask

    task automatic test_drop;
        int w;
        send_pkt(5'd24, 4, 0, w);
        chk_cnt("drop_cnt");
        send_pkt(5'd2, 2, 1, w);
        total++;
        if (w !== 2 || demux_select !== 5'd2) begin
            bad++;
            $display("FAIL after_drop: waits=%0d sel=%0d, required waits=2 sel=2", w, demux_select);
        end
        chk_cnt("after_drop_cnt");
    endtask

    task automatic test_backpressure;
        int w;
        beat_t e;
        drive_beat(mk(5'd9), 1'b0, 1, 5'd9, 1'b0, w);
        drive_beat(mk(5'd1), 1'b0, 1, 5'd9, 1'b0, w);
        out_ready = 1'b0;
        e.data = mk(5'd3); e.sel = 5'd9;
        sb.push_back(e);
        ing_data = e.data; ing_valid = 1'b1; ing_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (ing_ready !== 1'b0 || demux_select !== 5'd9 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall: ir=%b sel=%0d ov=%b, required ir=0 sel=9 ov=1",
                         ing_ready, demux_select, out_valid);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_beat(e.data, 1'b0, 0, 5'd9, 1'b0, w);
        drive_beat(mk(5'd4), 1'b1, 1, 5'd9, 1'b0, w);
        exp_pkt = exp_pkt + 16'd1;
        chk_cnt("bp_cnt");
    endtask

    task automatic test_ctrl_en;
        int w;
        logic [DW-1:0] h;
        drive_beat(mk(5'd3), 1'b0, 1, 5'd3, 1'b0, w);
        ctrl_en = 1'b0;
        drive_beat(mk(5'd8), 1'b1, 1, 5'd3, 1'b0, w);
        exp_pkt = exp_pkt + 16'd1;
        total++;
        if (w !== 1) begin
            bad++;
            $display("FAIL ctrl_en_finish: waits=%0d, required 1", w);
        end
        h = mk(5'd4);
        ing_data = h; ing_valid = 1'b1; ing_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ing_ready !== 1'b0 || route_active !== 1'b0 || demux_select !== 5'd3) begin
                bad++;
                $display("FAIL hold_idle: ir=%b act=%b sel=%0d, required ir=0 act=0 sel=3",
                         ing_ready, route_active, demux_select);
            end
        end
        @(posedge clk); #1;
        ctrl_en = 1'b1;
        drive_beat(h, 1'b1, 1, 5'd4, 1'b0, w);
        exp_pkt = exp_pkt + 16'd1;
        total++;
        if (w !== 2) begin
            bad++;
            $display("FAIL resume: waits=%0d, required 2", w);
        end
        chk_cnt("ctrl_en_cnt");
    endtask

    task automatic test_saturate_wrap;
        int w;
        logic [4:0] dl[3];
        dl[0] = 5'd31; dl[1] = 5'd25; dl[2] = 5'd24;
        force dut.drop_cnt = 16'hFFFD;
        #1;
        release dut.drop_cnt;
        exp_drop = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            send_pkt(dl[i], 1, 0, w);
            chk_cnt("drop_sat");
        end
        force dut.pkt_cnt = 16'hFFFF;
        #1;
        release dut.pkt_cnt;
        exp_pkt = 16'hFFFF;
        send_pkt(5'd23, 1, 1, w);
        chk_cnt("pkt_wrap");
    endtask

    task automatic test_cnt_clr;
        int w;
        drive_beat(mk(5'd11), 1'b0, 1, 5'd11, 1'b0, w);
        drive_beat(mk(5'd2), 1'b1, 1, 5'd11, 1'b1, w);
        exp_pkt = 16'd0;
        exp_drop = 16'd0;
        chk_cnt("clr_prio");
    endtask

    task automatic test_reset_mid_route;
        int w;
        drive_beat(mk(5'd6), 1'b0, 1, 5'd6, 1'b0, w);
        out_ready = 1'b0;
        ing_data = mk(5'd0); ing_valid = 1'b1; ing_last = 1'b0;
        @(negedge clk);
        total++;
        if (route_active !== 1'b1) begin
            bad++;
            $display("FAIL mid_route: route_active=%b, required 1", route_active);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (route_active !== 1'b0 || out_valid !== 1'b0 || ing_ready !== 1'b0 ||
            demux_select !== 5'd0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid: act=%b ov=%b ir=%b sel=%0d pkt=%h drop=%h, required all 0",
                     route_active, out_valid, ing_ready, demux_select, pkt_cnt, drop_cnt);
        end
        ing_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pkt = 0;
        exp_drop = 0;
        @(posedge clk); #1;
        send_pkt(5'd12, 1, 1, w);
        chk_cnt("post_reset_cnt");
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_back_to_back();
        test_drop();
        test_backpressure();
        test_ctrl_en();
        test_saturate_wrap();
        test_cnt_clr();
        test_reset_mid_route();
        repeat (2) @(posedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_left: %0d beats never forwarded, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
